data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port Data_MEM block RAM between two requesters: the CPU data
//  port (via MIO_BUS) and a secondary DMA/display reader-writer.
//  Sequences each access and returns a one-cycle ready/ack pulse.
//  cpu_ready drives the CPU's MIO_ready stall input.
//  Sits between MIO_BUS/DMA and the RAM ports wea/addra/dina/douta.
// PARAMETERS
//  ADDR_W      10   RAM word-address width
//  DATA_W      32   RAM data width
//  RD_LAT      1    RAM read latency in clk cycles, 1..3
//  STARVE_MAX  8    max consecutive CPU grants while DMA waits (fixed-priority mode)
// PORTS
//  clk        in   1       system clock, single domain
//  rst        in   1       asynchronous reset, active-high
//  cpu_req    in   1       CPU access request, held until cpu_ready
//  cpu_we     in   1       1=write, 0=read; stable while cpu_req
//  cpu_addr   in   ADDR_W  CPU word address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ready
//  cpu_ready  out  1       one-cycle completion pulse (to MIO_ready)
//  dma_req    in   1       DMA request, held until dma_ack
//  dma_we     in   1       DMA write enable
//  dma_addr   in   ADDR_W  DMA word address
//  dma_wdata  in   DATA_W  DMA write data
//  dma_rdata  out  DATA_W  DMA read data, valid with dma_ack
//  dma_ack    out  1       one-cycle completion pulse
//  ram_we     out  1       to Data_MEM wea
//  ram_addr   out  ADDR_W  to Data_MEM addra
//  ram_din    out  DATA_W  to Data_MEM dina
//  ram_dout   in   DATA_W  from Data_MEM douta
//  busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//  - All outputs registered.
//  - Reset values: every output 0, FSM=IDLE, starve_cnt=0, last_owner=DMA.
//  - FSM:
//    - IDLE -> GRANT when any req is sampled high; owner latched per policy.
//    - GRANT: ram_addr/ram_din/ram_we driven from owner for exactly 1 cycle.
//      Write -> DONE. Read -> WAIT.
//    - WAIT: counts RD_LAT cycles, then captures ram_dout into owner rdata -> DONE.
//    - DONE: owner ready/ack=1 for 1 cycle; ram_we=0 -> IDLE.
//  - Latency from req sampled at edge 0:
//    - write: ram_we at cycle 1, ack at cycle 2.
//    - read: ack at cycle 2+RD_LAT.
//  - Next request is sampled no earlier than the cycle after DONE (back-to-back: 1 idle cycle).
//  - req still high in the IDLE cycle after ack counts as a new request; requesters drop
//    req on the edge where they see ack.
//  - rdata holds its last value until the next read completes for that requester.
//  - Non-owner inputs are ignored mid-transaction; owner inputs are latched in IDLE->GRANT.
//  - Simultaneous cpu_req & dma_req in IDLE: resolved by policy (see CONFIGURATION).
//  - Reset mid-operation: transaction aborted, no ack issued, no further ram_we,
//    rdata cleared.
//  - ram_we is never asserted outside GRANT.
// CONFIGURATION
//  Macro ARB_ROUND_ROBIN_EN:
//  - Defined: on simultaneous requests, grant the requester opposite last_owner.
//    Strict alternation; starve_cnt unused, held at 0.
//  - Undefined: CPU has fixed priority. starve_cnt increments on each CPU grant made
//    while dma_req=1 and resets on any DMA grant. When starve_cnt==STARVE_MAX, the
//    next contended grant goes to DMA.
// STRUCTURE
//  - Package mio_arb_pkg:
//    - state enum {IDLE,GRANT,WAIT,DONE}
//    - owner constants OWN_CPU=1'b0, OWN_DMA=1'b1
//    - default ADDR_W/DATA_W
//  - One sub-module arb_policy: combinational grant pick plus the starve_cnt/last_owner
//    registers; this isolates the ARB_ROUND_ROBIN_EN ifdef.
// TESTING
//  1. Reset, CPU write addr 0x005 data 0xDEADBEEF
//     -> ram_we=1 for one cycle at cycle 1 with addr 0x005; cpu_ready pulse at cycle 2.
//  2. CPU read 0x005, RD_LAT=1
//     -> cpu_ready at cycle 3, cpu_rdata=0xDEADBEEF; dma_ack stays 0.
//  3. cpu_req & dma_req rise same cycle, fixed priority
//     -> CPU served first, DMA acked next; with ARB_ROUND_ROBIN_EN after a CPU-owned
//        transaction, DMA served first.
//  4. CPU requests continuously while DMA waits, STARVE_MAX=8, macro off
//     -> DMA granted on the 9th contended arbitration.
//  5. rst asserted during WAIT of a DMA read
//     -> all outputs 0 immediately, no dma_ack; after release IDLE, busy=0.
//  6. Back-to-back CPU writes 0x3FF then 0x000 (address wrap)
//     -> two ram_we pulses 3 cycles apart, correct addresses, no DMA interference.

Source files
------------

// File: rtl/mio_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mio_arb_pkg                                                     |
// | Desc     : Shared types and constants for the Data_MEM arbiter slice:      |
// |            FSM state encoding, owner encoding, default RAM geometry.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mio_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Owner encoding used for grant decisions and last_owner history
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // Default RAM geometry (1K x 32 Data_MEM)
    localparam int c_def_addr_w = 10;
    localparam int c_def_data_w = 32;

endpackage : mio_arb_pkg
`default_nettype wire

// File: rtl/arb_policy.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : arb_policy                                                      |
// | Desc     : Grant selection for the Data_MEM arbiter. Combinational owner   |
// |            pick plus the history registers it depends on.                  |
// |            Macro ARB_ROUND_ROBIN_EN: defined -> strict alternation on      |
// |            contention; undefined -> CPU priority with DMA starvation cap.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module arb_policy
    import mio_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,       // an arbitration is being made this cycle
    input  logic cpu_req,
    input  logic dma_req,
    output logic grant_owner
);

`ifdef ARB_ROUND_ROBIN_EN

    // Owner of the most recent grant; reset so the first contended grant goes to the CPU.
    // Round-robin needs no starvation counter.
    logic r_last_owner;

    // Contended requests alternate against the previous owner
    always_comb begin
        grant_owner = OWN_CPU;
        if (cpu_req && dma_req) begin
            grant_owner = ~r_last_owner;
        end else if (dma_req) begin
            grant_owner = OWN_DMA;
        end
    end

    // Remember who was granted last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_owner <= OWN_DMA;
        end else if (arb_en) begin
            r_last_owner <= grant_owner;
        end
    end

`else

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);

    // Consecutive CPU grants made while the DMA was kept waiting
    logic [CNT_W-1:0] r_starve_cnt;

    // CPU wins contention unless the DMA has already been passed over STARVE_MAX times
    always_comb begin
        grant_owner = OWN_CPU;
        if (cpu_req && dma_req) begin
            grant_owner = (r_starve_cnt == c_starve_max) ? OWN_DMA : OWN_CPU;
        end else if (dma_req) begin
            grant_owner = OWN_DMA;
        end
    end

    // Count CPU grants that bypass a waiting DMA; any DMA grant clears the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (arb_en) begin
            if (grant_owner == OWN_DMA) begin
                r_starve_cnt <= '0;
            end else if (dma_req && (r_starve_cnt != c_starve_max)) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

`endif

endmodule : arb_policy
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_mem_arbiter                                                |
// | Desc     : Shares the single-port Data_MEM block RAM between the CPU data  |
// |            port (MIO_BUS) and a DMA/display requester. Each access is      |
// |            sequenced IDLE->GRANT->(WAIT)->DONE and completed with a        |
// |            one-cycle ready/ack pulse. All outputs are registered.          |
// |            Macro ARB_ROUND_ROBIN_EN selects round-robin contention         |
// |            handling (default: CPU priority with DMA starvation cap).       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module data_mem_arbiter
    import mio_arb_pkg::*;
#(
    parameter int ADDR_W     = c_def_addr_w,
    parameter int DATA_W     = c_def_data_w,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    // CPU port (MIO_BUS)
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    // DMA / display port
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    // Data_MEM port A
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    // Status
    output logic              busy
);

    // WAIT lasts RD_LAT cycles; counter runs 0..RD_LAT-1
    localparam logic [1:0] c_lat_last = 2'(RD_LAT - 1);

    arb_state_t r_state;
    logic       r_owner;      // requester owning the current transaction
    logic       r_we;         // latched write flag of the owner
    logic [1:0] r_lat_cnt;

    logic       w_arb_en;
    logic       w_grant_owner;

    // A new transaction may only start from IDLE
    assign w_arb_en = (r_state == IDLE) && (cpu_req || dma_req);

    arb_policy #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb_policy (
        .clk         (clk),
        .rst         (rst),
        .arb_en      (w_arb_en),
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .grant_owner (w_grant_owner)
    );

    // Transaction sequencer: latches the owner's request, drives the RAM, returns data/ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= OWN_CPU;
            r_we      <= 1'b0;
            r_lat_cnt <= 2'd0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            dma_rdata <= '0;
            dma_ack   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_en) begin
                        r_state <= GRANT;
                        r_owner <= w_grant_owner;
                        busy    <= 1'b1;
                        if (w_grant_owner == OWN_CPU) begin
                            r_we     <= cpu_we;
                            ram_we   <= cpu_we;
                            ram_addr <= cpu_addr;
                            ram_din  <= cpu_wdata;
                        end else begin
                            r_we     <= dma_we;
                            ram_we   <= dma_we;
                            ram_addr <= dma_addr;
                            ram_din  <= dma_wdata;
                        end
                    end
                end
                GRANT: begin
                    // Write strobe lasts exactly the GRANT cycle
                    ram_we <= 1'b0;
                    if (r_we) begin
                        r_state   <= DONE;
                        cpu_ready <= (r_owner == OWN_CPU);
                        dma_ack   <= (r_owner == OWN_DMA);
                    end else begin
                        r_state   <= WAIT;
                        r_lat_cnt <= 2'd0;
                    end
                end
                WAIT: begin
                    if (r_lat_cnt == c_lat_last) begin
                        r_state <= DONE;
                        if (r_owner == OWN_CPU) begin
                            cpu_rdata <= ram_dout;
                            cpu_ready <= 1'b1;
                        end else begin
                            dma_rdata <= ram_dout;
                            dma_ack   <= 1'b1;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    cpu_ready <= 1'b0;
                    dma_ack   <= 1'b0;
                    ram_we    <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    ram_we  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : data_mem_arbiter
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_data_mem_arbiter                                             |
// | Desc     : Directed self-checking bench for data_mem_arbiter with a        |
// |            behavioural 1K x 32 RAM (read latency 1). Expectations follow   |
// |            ARB_ROUND_ROBIN_EN when the contention order differs.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_data_mem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_ready;
    logic              dma_req, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata, dma_rdata;
    logic              dma_ack;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (1),
        .STARVE_MAX (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_ack   (dma_ack),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .busy      (busy)
    );

    // Behavioural Data_MEM: one-cycle read latency, read-first
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; return sampled mid-cycle
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cpu_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        d = 'x;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (cpu_ready) begin
                d = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        tick;
    endtask

    logic              first_dma;
    int                cpu_acks, exp_cpu_acks;
    logic              dma_done;
    int                nwe, nrdy, c_first, c_second, dma_seen;
    logic [DATA_W-1:0] rd;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
`ifdef ARB_ROUND_ROBIN_EN
        first_dma    = 1'b1;
        exp_cpu_acks = 0;
`else
        first_dma    = 1'b0;
        exp_cpu_acks = 8;
`endif

        // Reset state
        @(negedge clk);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_dma_ack",   dma_ack,   0);
        check("rst_ram_we",    ram_we,    0);
        check("rst_busy",      busy,      0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        tick;
        rst = 1'b0;
        tick;

        // 1: CPU write 0x005 <- DEADBEEF
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h005; cpu_wdata = 32'hDEADBEEF;
        tick;
        check("t1_we_c1",    ram_we,    1);
        check("t1_addr_c1",  ram_addr,  32'h005);
        check("t1_din_c1",   ram_din,   32'hDEADBEEF);
        check("t1_busy_c1",  busy,      1);
        check("t1_rdy_c1",   cpu_ready, 0);
        tick;
        check("t1_rdy_c2",   cpu_ready, 1);
        check("t1_we_c2",    ram_we,    0);
        cpu_req = 0;
        tick;
        check("t1_rdy_c3",   cpu_ready, 0);
        check("t1_busy_c3",  busy,      0);

        // 2: CPU read 0x005, ready at cycle 3
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h005;
        tick;
        check("t2_we_c1",    ram_we,    0);
        check("t2_addr_c1",  ram_addr,  32'h005);
        tick;
        check("t2_rdy_c2",   cpu_ready, 0);
        tick;
        check("t2_rdy_c3",   cpu_ready, 1);
        check("t2_rdata",    cpu_rdata, 32'hDEADBEEF);
        check("t2_dma_ack",  dma_ack,   0);
        cpu_req = 0;
        tick;

        // 3: simultaneous CPU and DMA writes
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h010; cpu_wdata = 32'h11111111;
        dma_req = 1; dma_we = 1; dma_addr = 10'h020; dma_wdata = 32'h22222222;
        tick;
        check("t3_first_addr", ram_addr, first_dma ? 32'h020 : 32'h010);
        check("t3_first_we",   ram_we,   1);
        tick;
        check("t3_first_cpu_rdy", cpu_ready, first_dma ? 0 : 1);
        check("t3_first_dma_ack", dma_ack,   first_dma ? 1 : 0);
        if (first_dma) dma_req = 0; else cpu_req = 0;
        tick;
        check("t3_gap_busy",  busy,   0);
        check("t3_gap_we",    ram_we, 0);
        tick;
        check("t3_second_addr", ram_addr, first_dma ? 32'h010 : 32'h020);
        check("t3_second_we",   ram_we,   1);
        tick;
        check("t3_second_cpu_rdy", cpu_ready, first_dma ? 1 : 0);
        check("t3_second_dma_ack", dma_ack,   first_dma ? 0 : 1);
        cpu_req = 0; dma_req = 0;
        tick;

        // 4: CPU hammers while DMA reads 0x020
        cpu_acks = 0; dma_done = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h100; cpu_wdata = 32'h0;
        dma_req = 1; dma_we = 0; dma_addr = 10'h020;
        for (int c = 0; c < 200 && !dma_done; c++) begin
            tick;
            if (cpu_ready) begin
                cpu_acks++;
                cpu_addr = cpu_addr + 10'd1;
            end
            if (dma_ack) begin
                dma_done = 1;
                check("t4_dma_rdata", dma_rdata, 32'h22222222);
            end
        end
        cpu_req = 0; dma_req = 0;
        check("t4_dma_granted", dma_done, 1);
        check("t4_cpu_before_dma", cpu_acks, exp_cpu_acks);
        tick;

        // 5: reset during WAIT of a DMA read
        dma_req = 1; dma_we = 0; dma_addr = 10'h020;
        tick;
        check("t5_busy_grant", busy, 1);
        tick;
        check("t5_ack_wait", dma_ack, 0);
        rst = 1'b1;
        #1;
        check("t5_rst_busy",      busy,      0);
        check("t5_rst_dma_ack",   dma_ack,   0);
        check("t5_rst_ram_we",    ram_we,    0);
        check("t5_rst_dma_rdata", dma_rdata, 0);
        check("t5_rst_cpu_rdata", cpu_rdata, 0);
        check("t5_rst_ram_addr",  ram_addr,  0);
        dma_req = 0;
        tick;
        rst = 1'b0;
        tick;
        check("t5_post_busy",    busy,    0);
        check("t5_post_dma_ack", dma_ack, 0);

        // 6: back-to-back CPU writes 0x3FF then 0x000
        nwe = 0; nrdy = 0; c_first = -1; c_second = -1; dma_seen = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h3FF; cpu_wdata = 32'hAAAA5555;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (ram_we) begin
                if (nwe == 0) begin
                    c_first = c;
                    check("t6_addr_first", ram_addr, 32'h3FF);
                end else begin
                    c_second = c;
                    check("t6_addr_second", ram_addr, 32'h000);
                    check("t6_din_second",  ram_din,  32'h5555AAAA);
                end
                nwe++;
            end
            if (dma_ack) dma_seen++;
            if (cpu_ready) begin
                nrdy++;
                if (nrdy == 1) begin
                    cpu_addr = 10'h000; cpu_wdata = 32'h5555AAAA;
                end else begin
                    cpu_req = 0;
                end
            end
        end
        cpu_req = 0;
        check("t6_we_pulses",  nwe,                2);
        check("t6_first_cyc",  c_first,            1);
        check("t6_spacing",    c_second - c_first, 3);
        check("t6_dma_quiet",  dma_seen,           0);
        cpu_read(10'h3FF, rd);
        check("t6_rd_3ff", rd, 32'hAAAA5555);
        cpu_read(10'h000, rd);
        check("t6_rd_000", rd, 32'h5555AAAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_data_mem_arbiter
`default_nettype wire
